// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word layout for the PA-RISC pipeline: field positions,
// the bubble word and the default per-stage keep-masks (EX, MEM, WB).
package cpu_ctrl_pkg;

  localparam int CW = 21;

  localparam int SRD_LSB       = 19;
  localparam int SRD_W         = 2;
  localparam int PSW_LE_RE_LSB = 17;
  localparam int PSW_LE_RE_W   = 2;
  localparam int B_LSB         = 16;
  localparam int SOH_OP_LSB    = 13;
  localparam int SOH_OP_W      = 3;
  localparam int ALU_OP_LSB    = 9;
  localparam int ALU_OP_W      = 4;
  localparam int RAM_CTRL_LSB  = 5;
  localparam int RAM_CTRL_W    = 4;
  localparam int L_LSB         = 4;
  localparam int RF_LE_LSB     = 3;
  localparam int ID_SR_LSB     = 1;
  localparam int ID_SR_W       = 2;
  localparam int UB_LSB        = 0;

  localparam logic [CW-1:0] NOP_WORD = 21'h000000;

  // Ones over bits [lsb +: width] of a control word.
  function automatic logic [CW-1:0] field_mask(input int lsb, input int width);
    logic [CW-1:0] m;
    m = '0;
    for (int i = 0; i < CW; i++) begin
      if ((i >= lsb) && (i < lsb + width)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [CW-1:0] MASK_EX  = {CW{1'b1}};
  localparam logic [CW-1:0] MASK_MEM = field_mask(RAM_CTRL_LSB, RAM_CTRL_W)
                                     | field_mask(L_LSB, 1)
                                     | field_mask(RF_LE_LSB, 1);
  localparam logic [CW-1:0] MASK_WB  = field_mask(RF_LE_LSB, 1);

  localparam int DEF_NSTAGES = 3;
  localparam logic [DEF_NSTAGES*CW-1:0] DEF_STAGE_MASK = {MASK_WB, MASK_MEM, MASK_EX};

endpackage

// File: rtl/ctrl_stage_reg.sv
// One control-word pipeline stage: holds when en=0, loads a masked bubble
// or the masked upstream word otherwise.
module ctrl_stage_reg #(
  parameter int                    CW       = cpu_ctrl_pkg::CW,
  parameter logic [CW-1:0] MASK     = {CW{1'b1}},
  parameter logic [CW-1:0] NOP_WORD = cpu_ctrl_pkg::NOP_WORD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          bubble,
  input  logic [CW-1:0] d,
  input  logic          valid_d,
  output logic [CW-1:0] q,
  output logic          valid_q
);
  import cpu_ctrl_pkg::*;

  // Stage register; masking at load time keeps dropped fields at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= NOP_WORD & MASK;
      valid_q <= 1'b0;
    end else if (en) begin
      if (bubble) begin
        q       <= NOP_WORD & MASK;
        valid_q <= 1'b0;
      end else begin
        q       <= d & MASK;
        valid_q <= valid_d;
      end
    end
  end

endmodule

// File: rtl/ctrl_signal_pipe.sv
// Control-word pipeline from ID through NSTAGES stages with freeze, bubble
// injection, per-stage flush, valid tracking and a saturating bubble counter.
module ctrl_signal_pipe #(
  parameter int                            CW         = cpu_ctrl_pkg::CW,
  parameter int                            NSTAGES    = cpu_ctrl_pkg::DEF_NSTAGES,
  parameter logic [NSTAGES*CW-1:0] STAGE_MASK = cpu_ctrl_pkg::DEF_STAGE_MASK,
  parameter logic [CW-1:0]         NOP_WORD   = cpu_ctrl_pkg::NOP_WORD,
  parameter int                            CNTW       = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  S,
  input  logic                  stall,
  input  logic [NSTAGES-1:0]    flush,
  input  logic [CW-1:0]         ctrl_in,
  input  logic                  valid_in,
  output logic [NSTAGES*CW-1:0] stage_ctrl,
  output logic [NSTAGES-1:0]    stage_valid,
  output logic [CNTW-1:0]       bubble_cnt
);
  import cpu_ctrl_pkg::*;

  logic [NSTAGES-1:0] bubble;

  // Stage 0 also bubbles on CU-mux NOP select and load-use stall.
  always_comb begin
    bubble    = flush;
    bubble[0] = S | stall | flush[0];
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic [CW-1:0] d;
    logic          valid_d;

    if (k == 0) begin : g_first
      assign d       = ctrl_in;
      assign valid_d = valid_in;
    end else begin : g_next
      assign d       = stage_ctrl[(k-1)*CW +: CW];
      assign valid_d = stage_valid[k-1];
    end

    ctrl_stage_reg #(
      .CW       (CW),
      .MASK     (STAGE_MASK[k*CW +: CW]),
      .NOP_WORD (NOP_WORD)
    ) u_stage (
      .clk     (Clk),
      .rst_n   (Rst),
      .en      (En),
      .bubble  (bubble[k]),
      .d       (d),
      .valid_d (valid_d),
      .q       (stage_ctrl[k*CW +: CW]),
      .valid_q (stage_valid[k])
    );
  end

  // Counts stage-0 bubbles while advancing; sticks at all-ones.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bubble_cnt <= '0;
    end else if (En && bubble[0] && (bubble_cnt != {CNTW{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ctrl_signal_pipe.sv
// Directed self-checking bench for ctrl_signal_pipe (3 stages, 4-bit counter
// so saturation is reachable quickly).
module tb_ctrl_signal_pipe;

  localparam int CW   = 21;
  localparam int NS   = 3;
  localparam int CNTW = 4;

  logic                Clk;
  logic                Rst;
  logic                En;
  logic                S;
  logic                stall;
  logic [NS-1:0]       flush;
  logic [CW-1:0]       ctrl_in;
  logic                valid_in;
  logic [NS*CW-1:0]    stage_ctrl;
  logic [NS-1:0]       stage_valid;
  logic [CNTW-1:0]     bubble_cnt;

  int checks;
  int errors;

  ctrl_signal_pipe #(
    .CW      (CW),
    .NSTAGES (NS),
    .CNTW    (CNTW)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .En          (En),
    .S           (S),
    .stall       (stall),
    .flush       (flush),
    .ctrl_in     (ctrl_in),
    .valid_in    (valid_in),
    .stage_ctrl  (stage_ctrl),
    .stage_valid (stage_valid),
    .bubble_cnt  (bubble_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [NS*CW-1:0] e_ctrl,
                           input logic [NS-1:0] e_valid, input logic [CNTW-1:0] e_cnt);
    check_eq({tag, ".ctrl"},  64'(stage_ctrl),  64'(e_ctrl));
    check_eq({tag, ".valid"}, 64'(stage_valid), 64'(e_valid));
    check_eq({tag, ".cnt"},   64'(bubble_cnt),  64'(e_cnt));
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    Rst      = 1'b0;
    En       = 1'b1;
    S        = 1'b0;
    stall    = 1'b0;
    flush    = 3'b000;
    ctrl_in  = 21'h000000;
    valid_in = 1'b0;

    @(negedge Clk);
    check_all("reset", {21'h0, 21'h0, 21'h0}, 3'b000, 4'd0);
    Rst = 1'b1;

    // Fill the pipe with one instruction word.
    ctrl_in  = 21'h1ABCDE;
    valid_in = 1'b1;
    step();
    check_all("fill_e0", {21'h0, 21'h0, 21'h1ABCDE}, 3'b001, 4'd0);
    step();
    check_all("fill_e1", {21'h0, 21'h0000D8, 21'h1ABCDE}, 3'b011, 4'd0);
    step();
    check_all("fill_e2", {21'h000008, 21'h0000D8, 21'h1ABCDE}, 3'b111, 4'd0);

    // CU-mux NOP for two edges.
    S = 1'b1;
    step();
    check_all("s_e0", {21'h000008, 21'h0000D8, 21'h0}, 3'b110, 4'd1);
    step();
    check_all("s_e1", {21'h000008, 21'h0, 21'h0}, 3'b100, 4'd2);

    // Freeze overrides every bubble source.
    En    = 1'b0;
    flush = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("freeze", {21'h000008, 21'h0, 21'h0}, 3'b100, 4'd2);
    end
    En    = 1'b1;
    S     = 1'b0;
    flush = 3'b000;
    step();
    check_all("resume_e0", {21'h0, 21'h0, 21'h1ABCDE}, 3'b001, 4'd2);
    step();
    check_all("resume_e1", {21'h0, 21'h0000D8, 21'h1ABCDE}, 3'b011, 4'd2);

    // Flush the MEM stage only.
    flush   = 3'b010;
    ctrl_in = 21'h0F0F0F;
    step();
    check_all("flush1", {21'h000008, 21'h0, 21'h0F0F0F}, 3'b101, 4'd2);

    // Non-valid word loads without counting as a bubble.
    flush    = 3'b000;
    ctrl_in  = 21'h155555;
    valid_in = 1'b0;
    step();
    check_all("nvalid", {21'h0, 21'h000108, 21'h155555}, 3'b010, 4'd2);

    // Asynchronous reset mid-cycle, observed before the next edge.
    #1;
    Rst = 1'b0;
    #1;
    check_all("async_rst", {21'h0, 21'h0, 21'h0}, 3'b000, 4'd0);
    @(negedge Clk);
    Rst      = 1'b1;
    ctrl_in  = 21'h1ABCDE;
    valid_in = 1'b1;
    step();
    check_all("post_rst", {21'h0, 21'h0, 21'h1ABCDE}, 3'b001, 4'd0);

    // Flush of stage 0 alone counts as a bubble.
    flush = 3'b001;
    step();
    check_all("flush0", {21'h0, 21'h0000D8, 21'h0}, 3'b010, 4'd1);
    flush = 3'b000;

    // Saturation: 20 stall edges, counter must stop at 15.
    stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check_eq("sat_cnt", 64'(bubble_cnt), 64'((1 + i) > 15 ? 15 : (1 + i)));
      check_eq("sat_s0", 64'(stage_ctrl[CW-1:0]), 64'h0);
    end
    stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_signal_pipe.md
Name: ctrl_signal_pipe

Overview:
Parametrised control-word pipeline for the PA-RISC core. It carries the decoded control word from the ID-stage control-unit mux through NSTAGES registered stages (default EX, MEM, WB). At each stage, fields no longer needed downstream are masked off. It replaces the fixed per-stage control registers and adds:
- global freeze
- hazard bubble injection
- per-stage flush
- valid tracking
- a saturating bubble counter

Parameters:
- CW, 21, control word width; field order {SRD[20:19], PSW_LE_RE[18:17], B[16], SOH_OP[15:13], ALU_OP[12:9], RAM_CTRL[8:5], L[4], RF_LE[3], ID_SR[2:1], UB[0]}
- NSTAGES, 3, number of stages after ID; stage 0 = EX
- STAGE_MASK, {21'h000008, 21'h0001F8, 21'h1FFFFF}, packed NSTAGES*CW; slice k is the keep-mask for stage k (WB keeps RF_LE; MEM keeps RAM_CTRL/L/RF_LE; EX keeps all)
- NOP_WORD, 21'h0, control word of a bubble
- CNTW, 16, bubble counter width

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous active-low reset (0 = reset)
- En  input  1  global advance; 0 freezes every stage (memory wait)
- S  input  1  CU mux select; 1 forces a NOP into stage 0
- stall  input  1  load-use hazard; stage 0 loads a bubble
- flush  input  NSTAGES  flush[k]=1 makes stage k load a bubble
- ctrl_in  input  CW  control word from the control unit
- valid_in  input  1  ctrl_in carries a real instruction
- stage_ctrl  output  NSTAGES*CW  registered control word of each stage; slice k = stage k
- stage_valid  output  NSTAGES  valid bit per stage
- bubble_cnt  output  CNTW  saturating count of bubbles loaded into stage 0

Behaviour:
- Reset (Rst=0, asynchronous): every stage_ctrl slice = NOP_WORD & mask, stage_valid = 0, bubble_cnt = 0. Outputs change immediately, without waiting for a clock edge.
- All outputs are registered. Latency from ctrl_in to stage k is k+1 rising edges.
- Priority per stage each rising edge: Rst, then En=0 (hold), then bubble, then normal load.
- Stage 0 bubble condition: S | stall | flush[0]. Stage k>0 bubble condition: flush[k].
- Normal load:
  - stage 0 ← ctrl_in & mask0, valid ← valid_in
  - stage k ← stage(k-1) & maskk, valid ← valid(k-1)
- Bubble load: stage k ← NOP_WORD & maskk, valid ← 0. Stages downstream of a bubbled stage still advance normally in the same cycle.
- En=0: all stages and bubble_cnt hold, regardless of S, stall or flush.
- Masking is applied at load time, so masked bits always read 0.
- bubble_cnt increments by 1 on any edge with En=1 and a stage-0 bubble. It saturates at 2^CNTW-1 and never wraps.
- Flushes and stall in the same cycle are legal and OR together per stage.
- valid_in=0 with no bubble condition loads ctrl_in with valid 0. This is not counted as a bubble.
- Reset asserted mid-operation discards all in-flight words. The first edge after release behaves as a normal load.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - field offset/width localparams (SRD_LSB … UB_LSB)
  - CW
  - NOP_WORD
  - the default per-stage masks
- One sub-module, ctrl_stage_reg: a single stage register with inputs en, bubble, d, valid_d and a parameter MASK. It is instantiated NSTAGES times with a generate loop.
- Top level contains the bubble logic and the counter.

Test Plan:
1. Drop Rst to 0 mid-cycle while stages hold data → all stage_ctrl slices 0, stage_valid=000 and bubble_cnt=0 immediately, before the next edge.
2. ctrl_in=21'h1ABCDE, valid_in=1 on edge n, with S=stall=0, flush=0 and En=1:
   - stage 0 = 1ABCDE after edge n
   - stage 1 = 0000D8 after edge n+1
   - stage 2 = 000008 after edge n+2
   - valid bits propagate 001 → 011 → 111
3. S=1 for 2 edges with En=1 → stage 0 = 0 with valid 0 on both edges; downstream stages keep advancing; bubble_cnt 0 → 2.
4. En=0 for 3 edges with S=1 and flush=111 → every stage_ctrl slice, stage_valid and bubble_cnt unchanged; normal flow resumes when En returns to 1.
5. flush=3'b010 while stage 0=1ABCDE and stage 1=0000D8:
   - stage 1 = 0 with valid 0
   - stage 2 = 000008 (the old stage 1 word, masked)
   - stage 0 loads ctrl_in
   - bubble_cnt unchanged
6. CNTW=4, stall=1 for 20 edges → bubble_cnt reaches 15 and stays at 15 with no wrap.
